// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: fetch FSM encodings, PC increment and reset vector.
package mips_pkg;

   typedef enum logic [1:0] {
      S_RESET  = 2'd0,
      S_RUN    = 2'd1,
      S_BUBBLE = 2'd2
   } fetch_state_e;

   localparam logic [31:0] PC_INCR          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Redirect targets are forced onto a word boundary rather than trapped.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/adder_32_bit.sv
// Plain 32-bit modulo adder shared by the datapath.
module adder_32_bit (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] c
);

   assign c = a + b;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: PC register, next-PC select and a one-cycle
// bubble after every redirect so decode never sees the stale sequential fetch.
module pc_fetch_unit
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        if_valid,
   output logic        misaligned,
   output logic [31:0] fetch_count
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  count_q, count_d;
   logic         misaligned_q, misaligned_d;
   logic         redirect;
   logic [31:0]  target;

   adder_32_bit u_pc_adder (
      .a (pc_q),
      .b (PC_INCR),
      .c (pc_plus4)
   );

   // Jump outranks branch when both fire in the same cycle.
   assign redirect = jump | branch_taken;
   assign target   = jump ? jump_target : branch_target;

   // NOTE: every always_comb output gets a default first so no path leaves a latch.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      count_d      = count_q;
      misaligned_d = 1'b0;
      unique case (state_q)
         S_RESET: state_d = S_RUN;
         S_RUN, S_BUBBLE: begin
            if (redirect) begin
               pc_d         = word_align(target);
               misaligned_d = |target[1:0];
               state_d      = S_BUBBLE;
            end else if (!stall) begin
               if (state_q == S_RUN) begin
                  pc_d    = pc_plus4;
                  count_d = count_q + 32'd1;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         default: state_d = S_RESET;
      endcase
   end

   // NOTE: registers use non-blocking assignments so all state updates land together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_RESET;
         pc_q         <= RESET_PC;
         count_q      <= '0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         count_q      <= count_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign pc          = pc_q;
   assign if_valid    = (state_q == S_RUN);
   assign misaligned  = misaligned_q;
   assign fetch_count = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed stimulus, a behavioural
// fetch model compared every cycle, and literal expectations pinning the model.
module tb_pc_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic [31:0] pc, pc_plus4, fetch_count;
   logic        if_valid, misaligned;

   logic        w_stall, w_branch, w_jump;
   logic [31:0] w_btgt, w_jtgt;
   logic [31:0] w_pc, w_pc_plus4, w_count;
   logic        w_valid, w_mis;

   int n_checks = 0;
   int n_errors = 0;

   pc_fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .if_valid      (if_valid),
      .misaligned    (misaligned),
      .fetch_count   (fetch_count)
   );

   pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk           (clk),
      .rst           (rst),
      .stall         (w_stall),
      .branch_taken  (w_branch),
      .branch_target (w_btgt),
      .jump          (w_jump),
      .jump_target   (w_jtgt),
      .pc            (w_pc),
      .pc_plus4      (w_pc_plus4),
      .if_valid      (w_valid),
      .misaligned    (w_mis),
      .fetch_count   (w_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural model: a fetch is either freshly reset (one dead cycle),
   // waiting out a redirect bubble, or valid and advancing by a word.
   logic        model_on = 1'b0;
   logic        m_fresh, m_valid, m_mis;
   logic [31:0] m_pc, m_count;

   always @(posedge clk) begin
      if (rst) begin
         model_on = 1'b1;
         m_fresh  = 1'b1;
         m_valid  = 1'b0;
         m_mis    = 1'b0;
         m_pc     = 32'h0;
         m_count  = 32'h0;
      end else if (model_on) begin
         m_mis = 1'b0;
         if (m_fresh) begin
            m_fresh = 1'b0;
            m_valid = 1'b1;
         end else if (jump || branch_taken) begin
            logic [31:0] t;
            t       = jump ? jump_target : branch_target;
            m_mis   = (t % 4) != 0;
            m_pc    = t - (t % 4);
            m_valid = 1'b0;
         end else if (!stall) begin
            if (m_valid) begin
               m_pc    = m_pc + 32'd4;
               m_count = m_count + 32'd1;
            end else begin
               m_valid = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         check("model_pc",          pc,          m_pc);
         check("model_pc_plus4",    pc_plus4,    m_pc + 32'd4);
         check("model_if_valid",    {31'd0, if_valid},   {31'd0, m_valid});
         check("model_misaligned",  {31'd0, misaligned}, {31'd0, m_mis});
         check("model_fetch_count", fetch_count, m_count);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic lit(input string name, input logic [31:0] exp_pc, input logic exp_valid,
                      input logic exp_mis, input logic [31:0] exp_count);
      check({name, "_pc"},    pc,                      exp_pc);
      check({name, "_valid"}, {31'd0, if_valid},       {31'd0, exp_valid});
      check({name, "_mis"},   {31'd0, misaligned},     {31'd0, exp_mis});
      check({name, "_count"}, fetch_count,             exp_count);
   endtask

   task automatic clear_inputs();
      stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clear_inputs();
      branch_target = 32'h0; jump_target = 32'h0;
      w_stall = 1'b0; w_branch = 1'b0; w_jump = 1'b0;
      w_btgt = 32'h0; w_jtgt = 32'h0;
      tick(); tick();
      rst = 1'b0;
      lit("rst_hold", 32'h0, 1'b0, 1'b0, 32'd0);
      check("wrap_0", w_pc, 32'hFFFF_FFF8);
      tick();
      lit("first_fetch", 32'h0, 1'b1, 1'b0, 32'd0);
      check("wrap_1", w_pc, 32'hFFFF_FFF8);
      tick();
      lit("seq_4", 32'h4, 1'b1, 1'b0, 32'd1);
      check("wrap_2", w_pc, 32'hFFFF_FFFC);
      check("wrap_plus4", w_pc_plus4, 32'h0000_0000);
      tick();
      lit("seq_8", 32'h8, 1'b1, 1'b0, 32'd2);
      check("wrap_3", w_pc, 32'h0000_0000);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         lit("stall_run", 32'h8, 1'b1, 1'b0, 32'd2);
      end
      stall = 1'b0;
      tick();
      lit("stall_release", 32'hC, 1'b1, 1'b0, 32'd3);

      branch_taken = 1'b1; branch_target = 32'h100;
      jump = 1'b1; jump_target = 32'h203;
      tick();
      lit("jump_wins", 32'h200, 1'b0, 1'b1, 32'd3);
      clear_inputs();
      tick();
      lit("jump_valid", 32'h200, 1'b1, 1'b0, 32'd3);
      tick();
      lit("jump_seq", 32'h204, 1'b1, 1'b0, 32'd4);

      branch_taken = 1'b1; branch_target = 32'h300;
      tick();
      lit("br_bubble", 32'h300, 1'b0, 1'b0, 32'd4);
      branch_target = 32'h402;
      tick();
      lit("br_in_bubble", 32'h400, 1'b0, 1'b1, 32'd4);
      clear_inputs();
      tick();
      lit("br_valid", 32'h400, 1'b1, 1'b0, 32'd4);
      tick();
      lit("br_seq", 32'h404, 1'b1, 1'b0, 32'd5);

      jump = 1'b1; jump_target = 32'h500;
      tick();
      jump = 1'b0; stall = 1'b1;
      tick();
      lit("stall_bubble", 32'h500, 1'b0, 1'b0, 32'd5);
      stall = 1'b0;
      tick();
      lit("bubble_exit", 32'h500, 1'b1, 1'b0, 32'd5);

      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h601;
      tick();
      lit("redir_over_stall", 32'h600, 1'b0, 1'b1, 32'd5);
      clear_inputs();
      tick();

      // Short directed run with mixed controls, checked only by the model.
      for (int i = 0; i < 12; i++) begin
         stall         = (i % 3) == 1;
         branch_taken  = (i % 5) == 2;
         jump          = (i % 7) == 4;
         branch_target = 32'h1000 + i * 32'h11;
         jump_target   = 32'h2000 + i * 32'h7;
         tick();
      end
      clear_inputs();
      tick();

      jump = 1'b1; jump_target = 32'h700;
      tick();
      rst = 1'b1; jump_target = 32'h800;
      tick();
      lit("rst_in_bubble", 32'h0, 1'b0, 1'b0, 32'd0);
      rst = 1'b0; clear_inputs();
      tick();
      lit("rst_refetch", 32'h0, 1'b1, 1'b0, 32'd0);
      tick();
      lit("rst_seq", 32'h4, 1'b1, 1'b0, 32'd1);
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
